serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial binary subtractor: computes diff = a - b, LSB first, one bit per clock.
//   Uses a single full-subtractor cell plus a borrow flip-flop.
//   Datapath counterpart of the combinational adders in DDCO: subtraction instead of
//   addition, traded against latency. Serves area-constrained arithmetic behind a
//   start/done handshake.
// PARAMETERS
//   WIDTH  8  operand and result width in bits (>= 2)
// PORTS
//   clk    in   1      single clock, rising-edge
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  minuend; captured on the edge that accepts start
//   b      in   WIDTH  subtrahend; captured with a
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse: result valid
//   diff   out  WIDTH  a - b modulo 2^WIDTH; held until the next completion
//   bout   out  1      final borrow; 1 iff a < b (unsigned); held with diff
// BEHAVIOUR
//   Reset (async, any time, including mid-operation):
//     - state=IDLE; busy=0, done=0, diff=0, bout=0
//     - internal shift regs, bit counter and borrow FF cleared
//   FSM states IDLE -> SHIFT -> DONE -> IDLE
//     IDLE : start=1 at edge E0 -> load sa<=a, sb<=b, br<=0, cnt<=0; go to SHIFT
//            start=0 -> stay in IDLE
//     SHIFT: each edge processes bit x=sa[0], y=sb[0]:
//              d   = x ^ y ^ br
//              br' = (~x & y) | (~(x ^ y) & br)
//            sa, sb shift right; d enters the MSB of the result shift reg; cnt++.
//            On the WIDTH-th SHIFT edge (cnt == WIDTH-1):
//              - diff <= complete result, bout <= br'
//              - go to DONE
//     DONE : done=1 for exactly one cycle; next edge -> IDLE
//   Outputs decoded from state: busy=(state==SHIFT), done=(state==DONE).
//   Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 edges from
//     start sampling to the return to IDLE. Throughput: one op per WIDTH+2 cycles.
//   start while busy or done is ignored; no queuing. a/b changes after E0 are ignored.
//   diff/bout change only on a SHIFT->DONE transition or on reset.
//   Unsigned modulo arithmetic. bout is the borrow out of the MSB.
//   No X propagation from a/b into the outputs outside the load edge.
// TESTING
//   1. rst pulse mid-idle -> busy=0, done=0, diff=0, bout=0 immediately (async, no clk edge)
//   2. a=8'd200, b=8'd55, start 1 cycle -> done pulses once after 8 SHIFT edges;
//      diff=8'd145, bout=0
//   3. a=8'd5, b=8'd10 -> diff=8'hFB, bout=1
//   4. a=8'hFF, b=8'h00 -> diff=8'hFF, bout=0; then a=0, b=0 -> diff=0, bout=0
//   5. a=8'd100, b=8'd1, keep start=1 and change a/b during SHIFT and DONE:
//      - result = 8'd99, exactly one done pulse
//      - next op accepted only once back in IDLE
//   6. Start op, assert rst at the 4th SHIFT edge -> busy=0, diff=0 at once;
//      then a=8'd9, b=8'd3 -> diff=8'd6, bout=0 with normal latency

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b, LSB first) with a start/done handshake.
// Latency: done pulses in the cycle after the WIDTH-th SHIFT edge; one op per WIDTH+2 cycles.
// No backpressure: start is sampled only in IDLE, ignored while busy or done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Full-subtractor cell operating on the current LSBs.
  logic x_bit, y_bit, d_bit, br_nxt;

  // Next-state and datapath: one full-subtractor step per SHIFT edge.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    diff_d  = diff_q;
    br_d    = br_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    x_bit  = sa_q[0];
    y_bit  = sb_q[0];
    d_bit  = x_bit ^ y_bit ^ br_q;
    br_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);

    case (state_q)
      IDLE: begin
        // Operands are captured only on the accepting edge, so a/b never
        // reach the outputs at any other time.
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = br_nxt;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes expected {bout,diff},
// a monitor pops and compares on every done pulse.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [WIDTH:0] exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("diff", 32'(diff), 32'(e[WIDTH-1:0]));
          check("bout", 32'(bout), 32'(e[WIDTH]));
          check("busy_in_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || done !== 1'b0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wait_idle_timeout", 32'(n), 32'd0);
  endtask

  // One complete operation with latency and pulse-width checks.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic [WIDTH-1:0] ed, input logic eb);
    int cycles;
    wait_idle();
    start = 1'b1;
    a     = av;
    b     = bv;
    exp_q.push_back({eb, ed});
    @(negedge clk);
    start  = 1'b0;
    a      = WIDTH'($urandom);
    b      = WIDTH'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    cycles = 1;
    while (done !== 1'b1 && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
    check("latency", 32'(cycles), 32'(WIDTH + 1));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic operations with hand-computed results.
    do_op(8'd200, 8'd55, 8'd145, 1'b0);

    // Async reset mid-idle: clears held result without a clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("idle_rst_diff", 32'(diff), 32'd0);
    check("idle_rst_bout", 32'(bout), 32'd0);
    check("idle_rst_busy", 32'(busy), 32'd0);
    check("idle_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(8'd5,   8'd10,  8'hFB,  1'b1);
    do_op(8'hFF,  8'h00,  8'hFF,  1'b0);
    do_op(8'h00,  8'h00,  8'h00,  1'b0);
    do_op(8'h80,  8'h7F,  8'h01,  1'b0);
    do_op(8'h00,  8'h01,  8'hFF,  1'b1);
    do_op(8'h5A,  8'h5A,  8'h00,  1'b0);

    // Start held high with operands changing during SHIFT and DONE.
    wait_idle();
    start = 1'b1;
    a     = 8'd100;
    b     = 8'd1;
    exp_q.push_back({1'b0, 8'd99});
    for (int i = 1; i <= WIDTH + 1; i++) begin
      @(negedge clk);
      a = 8'(i * 23);
      b = 8'(i * 7 + 1);
      if (i <= WIDTH) begin
        check("held_busy", 32'(busy), 32'd1);
        check("held_no_done", 32'(done), 32'd0);
      end else begin
        check("held_done", 32'(done), 32'd1);
      end
    end
    // Next edge returns to IDLE; the edge after that accepts this op.
    a = 8'd50;
    b = 8'd20;
    @(negedge clk);
    check("held_idle_gap_busy", 32'(busy), 32'd0);
    check("held_idle_gap_done", 32'(done), 32'd0);
    exp_q.push_back({1'b0, 8'd30});
    @(negedge clk);
    start = 1'b0;
    check("held_reaccept_busy", 32'(busy), 32'd1);
    wait_idle();

    // Reset at the 4th SHIFT edge aborts the op; no result expected from it.
    start = 1'b1;
    a     = 8'd77;
    b     = 8'd33;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(8'd9, 8'd3, 8'd6, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
